// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: command/error codes,
// ASCII constants, FSM state encoding and small byte-classification helpers.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_TEMP      = 3'd1,
    CMD_HUMI      = 3'd2,
    CMD_CLEAR     = 3'd3,
    CMD_BACKLIGHT = 3'd4,
    CMD_POS       = 3'd5
  } cmd_code_t;

  typedef enum logic [1:0] {
    ERR_SYNTAX  = 2'd0,
    ERR_RANGE   = 2'd1,
    ERR_OVERRUN = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARG     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_H  = 8'h48;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_P  = 8'h50;

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  // Maps an (uppercase) command letter to its code; CMD_NONE means "not a command".
  function automatic cmd_code_t decode_letter(input logic [7:0] b);
    case (b)
      ASCII_T: return CMD_TEMP;
      ASCII_H: return CMD_HUMI;
      ASCII_C: return CMD_CLEAR;
      ASCII_B: return CMD_BACKLIGHT;
      ASCII_P: return CMD_POS;
      default: return CMD_NONE;
    endcase
  endfunction

  // B and P are meaningless without a value; T, H and C must not carry one.
  function automatic logic needs_arg(input cmd_code_t c);
    return (c == CMD_BACKLIGHT) || (c == CMD_POS);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte timeout for a partially received line. Down-counter that is
// reloaded while disabled or on every received byte; expired is asserted
// once the full TIMEOUT_MS*CLK_FREQ/1000 cycles elapse with no byte.
// TIMEOUT_MS = 0 removes the counter and ties expired low.
module uart_cmd_timeout #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TIMEOUT_MS = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic expired
);

  // 64-bit arithmetic: 100 MHz x 100 ms does not fit in 32 bits.
  localparam longint unsigned LIMIT = 64'(TIMEOUT_MS) * 64'(CLK_FREQ) / 64'd1000;

  generate
    if (LIMIT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset, enable, restart};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
      logic [CNT_W-1:0] cnt_reg;

      // Reload on reset/restart/idle, otherwise count down and park at zero.
      always_ff @(posedge clk) begin
        if (reset || restart || !enable) begin
          cnt_reg <= CNT_W'(LIMIT - 64'd1);
        end else if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end

      // A byte in the expiry cycle wins, so expiry is masked by restart.
      assign expired = enable && !restart && (cnt_reg == '0);
    end
  endgenerate

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser downstream of the UART receiver.
// Lines are <letter>[0-3 digits]<CR|LF>; valid lines become one command on a
// valid/ready interface, bad lines produce a single one-cycle error strobe.
// Optional build macro: UART_CMD_LOWERCASE_EN (accept lowercase letters).
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TIMEOUT_MS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic [1:0] debug_state
);

  state_t     state_reg, state_next;
  cmd_code_t  pend_code_reg, pend_code_next;
  logic [9:0] acc_reg, acc_next;
  logic [1:0] ndig_reg, ndig_next;
  logic       cmd_valid_reg, cmd_valid_next;
  cmd_code_t  cmd_code_reg, cmd_code_next;
  logic [7:0] cmd_arg_reg, cmd_arg_next;
  logic       err_valid_reg, err_valid_next;
  err_code_t  err_code_reg, err_code_next;

  logic [7:0]  letter;
  cmd_code_t   letter_code;
  logic [11:0] acc_wide;
  logic        issue;
  logic        tmo_expired;

`ifdef UART_CMD_LOWERCASE_EN
  assign letter = ((rx_data >= 8'h61) && (rx_data <= 8'h7A)) ? (rx_data - 8'h20) : rx_data;
`else
  assign letter = rx_data;
`endif

  assign letter_code = decode_letter(letter);

  // Wide enough for 255*10+9 so the range check sees the true value.
  assign acc_wide = ({2'b00, acc_reg} * 12'd10) + {8'h00, rx_data[3:0]};

  uart_cmd_timeout #(
    .CLK_FREQ  (CLK_FREQ),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (state_reg != S_IDLE),
    .restart(rx_valid),
    .expired(tmo_expired)
  );

  // Next-state, line validation and command/error output logic.
  always_comb begin
    state_next     = state_reg;
    pend_code_next = pend_code_reg;
    acc_next       = acc_reg;
    ndig_next      = ndig_reg;
    cmd_valid_next = cmd_valid_reg;
    cmd_code_next  = cmd_code_reg;
    cmd_arg_next   = cmd_arg_reg;
    err_valid_next = 1'b0;
    err_code_next  = err_code_reg;
    issue          = 1'b0;

    if (rx_valid) begin
      case (state_reg)
        S_IDLE: begin
          if (is_term(rx_data)) begin
            state_next = S_IDLE;
          end else if (letter_code != CMD_NONE) begin
            pend_code_next = letter_code;
            acc_next       = '0;
            ndig_next      = '0;
            state_next     = S_ARG;
          end else begin
            err_valid_next = 1'b1;
            err_code_next  = ERR_SYNTAX;
            state_next     = S_DISCARD;
          end
        end
        S_ARG: begin
          if (is_digit(rx_data)) begin
            if ((ndig_reg == 2'd3) || (acc_wide > 12'd255)) begin
              err_valid_next = 1'b1;
              err_code_next  = ERR_RANGE;
              state_next     = S_DISCARD;
            end else begin
              acc_next  = acc_wide[9:0];
              ndig_next = ndig_reg + 2'd1;
            end
          end else if (is_term(rx_data)) begin
            state_next = S_IDLE;
            if (needs_arg(pend_code_reg) != (ndig_reg != 2'd0)) begin
              err_valid_next = 1'b1;
              err_code_next  = ERR_SYNTAX;
            end else begin
              issue = 1'b1;
            end
          end else begin
            err_valid_next = 1'b1;
            err_code_next  = ERR_SYNTAX;
            state_next     = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (is_term(rx_data)) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end else if (tmo_expired) begin
      state_next = S_IDLE;
      if (state_reg == S_ARG) begin
        err_valid_next = 1'b1;
        err_code_next  = ERR_TIMEOUT;
      end
    end

    // A same-cycle accept frees the slot, so the new command may load.
    if (issue) begin
      if (!cmd_valid_reg || cmd_ready) begin
        cmd_valid_next = 1'b1;
        cmd_code_next  = pend_code_reg;
        cmd_arg_next   = acc_reg[7:0];
      end else begin
        err_valid_next = 1'b1;
        err_code_next  = ERR_OVERRUN;
      end
    end else if (cmd_valid_reg && cmd_ready) begin
      cmd_valid_next = 1'b0;
      cmd_code_next  = CMD_NONE;
      cmd_arg_next   = '0;
    end
  end

  // State and output registers; reset drops any partial line and pending command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      pend_code_reg <= CMD_NONE;
      acc_reg       <= '0;
      ndig_reg      <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_code_reg  <= CMD_NONE;
      cmd_arg_reg   <= '0;
      err_valid_reg <= 1'b0;
      err_code_reg  <= ERR_SYNTAX;
    end else begin
      state_reg     <= state_next;
      pend_code_reg <= pend_code_next;
      acc_reg       <= acc_next;
      ndig_reg      <= ndig_next;
      cmd_valid_reg <= cmd_valid_next;
      cmd_code_reg  <= cmd_code_next;
      cmd_arg_reg   <= cmd_arg_next;
      err_valid_reg <= err_valid_next;
      err_code_reg  <= err_code_next;
    end
  end

  assign cmd_valid   = cmd_valid_reg;
  assign cmd_code    = cmd_code_reg;
  assign cmd_arg     = cmd_arg_reg;
  assign err_valid   = err_valid_reg;
  assign err_code    = err_code_reg;
  assign debug_state = state_reg;

endmodule
